// File: rtl/weight_buffer_pp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | weight_buffer_pp_pkg : shared types, geometry and lane mapping for the      |
// |                        ping-pong weight buffer                              |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package weight_buffer_pp_pkg;

  localparam int unsigned ROW_BYTES  = 11;
  localparam int unsigned MEM_W      = 64;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned NUM_LANES  = 6;
  localparam int unsigned NUM_LAYERS = 4;
  localparam int unsigned MAX_ROWS   = NUM_LAYERS * ROW_BYTES;

  localparam int unsigned ROW_BITS = ROW_BYTES * 8;
  localparam int unsigned BEATS    = (ROW_BITS + MEM_W - 1) / MEM_W;
  localparam int unsigned WORDS    = (ROW_BITS + WORD_W - 1) / WORD_W;
  localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WORD_CW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned LAYER_W  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int unsigned ROW_AW   = $clog2(MAX_ROWS);
  localparam int unsigned IDX_W    = 5;

  localparam int unsigned STRIDE_WIDE   = 11;
  localparam int unsigned STRIDE_MID    = 5;
  localparam int unsigned STRIDE_NARROW = 3;
  localparam int unsigned MODE2_OFS     = 6;
  localparam int unsigned WIDE_LANES    = 6;
  localparam int unsigned MID_LANES     = 5;

  typedef enum logic [1:0] {
    MODE1 = 2'd0,
    MODE2 = 2'd1,
    MODE3 = 2'd2,
    MODE4 = 2'd3
  } OP_MODE;

  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  packet_idx;
    logic [WORD_W-1:0] data;
  } PE_IN_PACKET;

  typedef enum logic [0:0] {
    L_IDLE = 1'b0,
    L_FILL = 1'b1
  } load_state_t;

  typedef enum logic [0:0] {
    O_IDLE = 1'b0,
    O_SEND = 1'b1
  } drain_state_t;

  function automatic logic [ROW_AW-1:0] rows_per_mode(input OP_MODE m);
    case (m)
      MODE3:   return ROW_AW'(NUM_LAYERS * STRIDE_MID);
      MODE4:   return ROW_AW'(NUM_LAYERS * STRIDE_NARROW);
      default: return ROW_AW'(MAX_ROWS);
    endcase
  endfunction

  // Returns {lane_used, row_index} for one lane of one layer.
  function automatic logic [ROW_AW:0] lane_map(input OP_MODE m,
                                               input logic [LAYER_W-1:0] layer,
                                               input int unsigned lane);
    int unsigned l;
    int unsigned base;
    logic        hit;
    l    = 32'(layer);
    base = 0;
    hit  = 1'b0;
    case (m)
      MODE1: begin
        hit  = (lane < WIDE_LANES);
        base = l * STRIDE_WIDE + lane;
      end
      MODE2: begin
        hit  = (lane < MID_LANES);
        base = l * STRIDE_WIDE + MODE2_OFS + lane;
      end
      MODE3: begin
        hit  = (lane < MID_LANES);
        base = l * STRIDE_MID + lane;
      end
      default: begin
        hit  = 1'b1;
        base = l * STRIDE_NARROW + lane % STRIDE_NARROW;
      end
    endcase
    return {hit, ROW_AW'(base)};
  endfunction

  // Word 0 carries the short top slice of the row, zero-extended.
  function automatic logic [WORD_W-1:0] word_of(input logic [ROW_BITS-1:0] row,
                                                input logic [WORD_CW-1:0] w);
    case (w)
      WORD_CW'(0): return WORD_W'(row[ROW_BITS-1:2*WORD_W]);
      WORD_CW'(1): return row[2*WORD_W-1:WORD_W];
      default:     return row[WORD_W-1:0];
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/weight_buffer_pp_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_bank : one filter bank, beat-wide write port and per-lane row reads      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_bank
  import weight_buffer_pp_pkg::*;
#(
  parameter int unsigned NUM_RD = NUM_LANES
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [ROW_AW-1:0]   wr_row_i,
  input  logic [BEAT_W-1:0]   wr_beat_i,
  input  logic [MEM_W-1:0]    wr_data_i,
  input  logic [ROW_AW-1:0]   rd_row_i  [NUM_RD],
  output logic [ROW_BITS-1:0] rd_data_o [NUM_RD]
);

  logic [ROW_BITS-1:0] mem_q [MAX_ROWS];

  // The last beat only covers the row bits above the previous beats.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < ROW_BITS; b++) begin
        if (BEAT_W'(b / MEM_W) == wr_beat_i) begin
          mem_q[wr_row_i][b] <= wr_data_i[b % MEM_W];
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_data_o[r] = mem_q[rd_row_i[r]];
    end
  end

endmodule
`default_nettype wire

// File: rtl/weight_buffer_pp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | weight_buffer_pp : ping-pong filter store, DRAM fill on one bank while the  |
// |                    other drains lane packets to the PE array                |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module weight_buffer_pp
  import weight_buffer_pp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  OP_MODE            mode_in,
  input  logic              load_start,
  output logic              mem_req,
  input  logic              mem_valid,
  input  logic [MEM_W-1:0]  mem_data,
  output logic              load_reject,
  input  logic              out_start,
  input  logic              pe_ready,
  output PE_IN_PACKET       packet_out [NUM_LANES],
  output logic              out_done,
  output logic [1:0]        bank_full
);

  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [WORD_CW-1:0] LAST_WORD  = WORD_CW'(WORDS - 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  load_state_t          load_state_q, load_state_d;
  drain_state_t         drain_state_q, drain_state_d;
  logic                 fill_ptr_q, fill_ptr_d;
  logic                 drain_ptr_q, drain_ptr_d;
  logic [1:0]           bank_full_q, bank_full_d;
  OP_MODE               tag_q [2];
  OP_MODE               tag_d [2];
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [ROW_AW-1:0]    row_q, row_d;
  logic                 mem_req_q, mem_req_d;
  logic                 load_reject_q, load_reject_d;
  logic                 out_done_q, out_done_d;
  logic [LAYER_W-1:0]   layer_q, layer_d;
  logic [WORD_CW-1:0]   word_q, word_d;
  PE_IN_PACKET          pkt_q  [NUM_LANES];
  PE_IN_PACKET          pkt_d  [NUM_LANES];
  PE_IN_PACKET          pkt_rd [NUM_LANES];

  logic [LAYER_W-1:0]   rd_layer;
  logic [WORD_CW-1:0]   rd_word;
  logic [ROW_AW-1:0]    rd_row [NUM_LANES];
  logic [NUM_LANES-1:0] rd_hit;
  logic [ROW_BITS-1:0]  bank_rd [2][NUM_LANES];
  logic [ROW_AW-1:0]    fill_last_row;
  logic [1:0]           bank_set, bank_clr, full_eff;
  logic                 wr_en;

  assign fill_last_row = rows_per_mode(tag_q[fill_ptr_q]) - 1'b1;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    wb_bank #(.NUM_RD(NUM_LANES)) u_bank (
      .clk       (clk),
      .we_i      (wr_en && (fill_ptr_q == 1'(b))),
      .wr_row_i  (row_q),
      .wr_beat_i (beat_q),
      .wr_data_i (mem_data),
      .rd_row_i  (rd_row),
      .rd_data_o (bank_rd[b])
    );
  end

  // Read address always targets the set that would be presented next.
  always_comb begin
    rd_layer = '0;
    rd_word  = '0;
    if (drain_state_q == O_SEND) begin
      if (word_q == LAST_WORD) begin
        rd_layer = layer_q + 1'b1;
      end else begin
        rd_layer = layer_q;
        rd_word  = word_q + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      {rd_hit[i], rd_row[i]} = lane_map(tag_q[drain_ptr_q], rd_layer, i);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      pkt_rd[i] = '0;
      if (rd_hit[i]) begin
        pkt_rd[i].valid      = 1'b1;
        pkt_rd[i].packet_idx = {rd_layer, 3'(i)};
        pkt_rd[i].data       = word_of(bank_rd[drain_ptr_q][i], rd_word);
      end
    end
  end

  always_comb begin
    load_state_d  = load_state_q;
    drain_state_d = drain_state_q;
    fill_ptr_d    = fill_ptr_q;
    drain_ptr_d   = drain_ptr_q;
    tag_d         = tag_q;
    beat_d        = beat_q;
    row_d         = row_q;
    mem_req_d     = mem_req_q;
    load_reject_d = 1'b0;
    out_done_d    = 1'b0;
    layer_d       = layer_q;
    word_d        = word_q;
    pkt_d         = pkt_q;
    bank_set      = '0;
    bank_clr      = '0;
    wr_en         = 1'b0;

    case (drain_state_q)
      O_IDLE: begin
        if (out_start && bank_full_q[drain_ptr_q]) begin
          drain_state_d = O_SEND;
          layer_d       = rd_layer;
          word_d        = rd_word;
          pkt_d         = pkt_rd;
        end
      end
      default: begin
        if (pe_ready) begin
          if (layer_q == LAST_LAYER && word_q == LAST_WORD) begin
            drain_state_d         = O_IDLE;
            pkt_d                 = '{default: '0};
            out_done_d            = 1'b1;
            bank_clr[drain_ptr_q] = 1'b1;
            drain_ptr_d           = ~drain_ptr_q;
          end else begin
            layer_d = rd_layer;
            word_d  = rd_word;
            pkt_d   = pkt_rd;
          end
        end
      end
    endcase

    // A bank freed by a drain finishing this cycle may be refilled at once.
    full_eff = bank_full_q & ~bank_clr;

    case (load_state_q)
      L_IDLE: begin
        if (load_start) begin
          if (!full_eff[fill_ptr_q]) begin
            load_state_d      = L_FILL;
            tag_d[fill_ptr_q] = mode_in;
            beat_d            = '0;
            row_d             = '0;
            mem_req_d         = 1'b1;
          end else begin
            load_reject_d = 1'b1;
          end
        end
      end
      default: begin
        if (mem_valid && mem_req_q) begin
          wr_en = 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (row_q == fill_last_row) begin
              bank_set[fill_ptr_q] = 1'b1;
              fill_ptr_d           = ~fill_ptr_q;
              mem_req_d            = 1'b0;
              load_state_d         = L_IDLE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
    endcase

    bank_full_d = (bank_full_q | bank_set) & ~bank_clr;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      load_state_q  <= L_IDLE;
      drain_state_q <= O_IDLE;
      fill_ptr_q    <= 1'b0;
      drain_ptr_q   <= 1'b0;
      bank_full_q   <= '0;
      tag_q         <= '{default: MODE1};
      beat_q        <= '0;
      row_q         <= '0;
      mem_req_q     <= 1'b0;
      load_reject_q <= 1'b0;
      out_done_q    <= 1'b0;
      layer_q       <= '0;
      word_q        <= '0;
      pkt_q         <= '{default: '0};
    end else begin
      load_state_q  <= load_state_d;
      drain_state_q <= drain_state_d;
      fill_ptr_q    <= fill_ptr_d;
      drain_ptr_q   <= drain_ptr_d;
      bank_full_q   <= bank_full_d;
      tag_q         <= tag_d;
      beat_q        <= beat_d;
      row_q         <= row_d;
      mem_req_q     <= mem_req_d;
      load_reject_q <= load_reject_d;
      out_done_q    <= out_done_d;
      layer_q       <= layer_d;
      word_q        <= word_d;
      pkt_q         <= pkt_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign load_reject = load_reject_q;
  assign out_done    = out_done_q;
  assign bank_full   = bank_full_q;
  assign packet_out  = pkt_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_buffer_pp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_weight_buffer_pp : scoreboard bench for the ping-pong weight buffer      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_weight_buffer_pp;
  import weight_buffer_pp_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  OP_MODE            mode_in = MODE1;
  logic              load_start = 1'b0;
  logic              mem_req;
  logic              mem_valid = 1'b0;
  logic [MEM_W-1:0]  mem_data = '0;
  logic              load_reject;
  logic              out_start = 1'b0;
  logic              pe_ready = 1'b0;
  PE_IN_PACKET       packet_out [NUM_LANES];
  logic              out_done;
  logic [1:0]        bank_full;

  weight_buffer_pp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_in     (mode_in),
    .load_start  (load_start),
    .mem_req     (mem_req),
    .mem_valid   (mem_valid),
    .mem_data    (mem_data),
    .load_reject (load_reject),
    .out_start   (out_start),
    .pe_ready    (pe_ready),
    .packet_out  (packet_out),
    .out_done    (out_done),
    .bank_full   (bank_full)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  PE_IN_PACKET sb [$];
  int          sets_seen = 0;
  int          done_seen = 0;
  bit          exp_done = 1'b0;
  OP_MODE      m_mode [2];
  logic [7:0]  m_seed [2];
  logic [7:0]  m_step [2];
  int          m_fill = 0;
  int          m_drain = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Row r of a load: byte j = seed + r + j*stp.
  function automatic logic [ROW_BITS-1:0] row_val(input logic [7:0] seed, input logic [7:0] stp, input int r);
    logic [ROW_BITS-1:0] v;
    for (int j = 0; j < ROW_BYTES; j++) v[8*j +: 8] = seed + 8'(r) + 8'(j) * stp;
    return v;
  endfunction

  function automatic int rows_of(input OP_MODE m);
    case (m)
      MODE3:   return 20;
      MODE4:   return 12;
      default: return 44;
    endcase
  endfunction

  function automatic PE_IN_PACKET exp_pkt(input OP_MODE m, input logic [7:0] seed, input logic [7:0] stp,
                                          input int L, input int w, input int i);
    PE_IN_PACKET         p;
    logic [ROW_BITS-1:0] rv;
    int                  r;
    p = '0;
    r = -1;
    case (m)
      MODE1: r = L * 11 + i;
      MODE2: if (i < 5) r = L * 11 + 6 + i;
      MODE3: if (i < 5) r = L * 5 + i;
      MODE4: r = L * 3 + (i % 3);
    endcase
    if (r >= 0) begin
      rv           = row_val(seed, stp, r);
      p.valid      = 1'b1;
      p.packet_idx = 5'(L * 8 + i);
      if (w == 0)      p.data = {8'h00, rv[87:64]};
      else if (w == 1) p.data = rv[63:32];
      else             p.data = rv[31:0];
    end
    return p;
  endfunction

  function automatic bit any_valid();
    bit v = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) v |= packet_out[i].valid;
    return v;
  endfunction

  task automatic chk_pkts_zero(input string name);
    for (int i = 0; i < NUM_LANES; i++) chk($sformatf("%s_lane%0d", name, i), 64'(packet_out[i]), 64'd0);
  endtask

  task automatic push_sets(input int b);
    for (int L = 0; L < 4; L++)
      for (int w = 0; w < 3; w++)
        for (int i = 0; i < NUM_LANES; i++)
          sb.push_back(exp_pkt(m_mode[b], m_seed[b], m_step[b], L, w, i));
  endtask

  // Monitor: every accepted packet set is popped and compared lane by lane.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (out_done) done_seen++;
      if (exp_done) begin
        chk("out_done_after_last_set", 64'(out_done), 64'd1);
        exp_done = 1'b0;
      end
      if (any_valid() && pe_ready) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_set lane%0d: got %0h required no set", i, packet_out[i]);
          end else begin
            chk($sformatf("set%0d_lane%0d", sets_seen % 12, i), 64'(packet_out[i]), 64'(sb.pop_front()));
          end
        end
        sets_seen++;
        if (sets_seen % 12 == 0) exp_done = 1'b1;
      end
    end
  end

  task automatic do_load(input OP_MODE m, input logic [7:0] seed, input logic [7:0] stp, input bit rnd);
    int                  b = m_fill;
    int                  nbeats = 2 * rows_of(m);
    int                  k = 0;
    int                  guard = 0;
    bit                  take;
    logic [ROW_BITS-1:0] rv;
    m_mode[b] = m;
    m_seed[b] = seed;
    m_step[b] = stp;
    mode_in    = m;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    mode_in    = MODE1;
    chk("mem_req_after_start", 64'(mem_req), 64'd1);
    while (k < nbeats && guard < 2000) begin
      mem_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rv        = row_val(seed, stp, k / 2);
      if (!mem_valid)  mem_data = {$urandom, $urandom};
      else if (k % 2 == 0) mem_data = rv[63:0];
      else             mem_data = {40'hA5A5A5A5A5, rv[87:64]};
      take = mem_valid && mem_req;
      step();
      guard++;
      if (take) k++;
    end
    mem_valid = 1'b0;
    chk("load_beat_count", 64'(k), 64'(nbeats));
    chk("mem_req_drop_after_last", 64'(mem_req), 64'd0);
    chk("bank_full_after_load", 64'(bank_full[b]), 64'd1);
    m_fill ^= 1;
  endtask

  task automatic do_drain(input int rmode);
    int b = m_drain;
    int d0 = done_seen;
    int guard = 0;
    push_sets(b);
    out_start = 1'b1;
    step();
    out_start = 1'b0;
    chk("first_set_valid", 64'(packet_out[0].valid), 64'd1);
    while (done_seen == d0 && guard < 300) begin
      case (rmode)
        0:       pe_ready = 1'b1;
        1:       pe_ready = 1'(guard % 2);
        default: pe_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      guard++;
    end
    pe_ready = 1'b0;
    chk("drain_done_seen", 64'(done_seen - d0), 64'd1);
    chk_pkts_zero("pkt_clear");
    chk("bank_full_cleared", 64'(bank_full[b]), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    step();
    step();
    chk("single_out_done", 64'(done_seen - d0), 64'd1);
    m_drain ^= 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b1;
    step();
    step();
    chk("rst_bank_full", 64'(bank_full), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_load_reject", 64'(load_reject), 64'd0);
    chk("rst_out_done", 64'(out_done), 64'd0);
    chk_pkts_zero("rst_pkt");
    rst_n = 1'b0;
    step();

    // out_start with nothing loaded is ignored
    out_start = 1'b1;
    step();
    out_start = 1'b0;
    pe_ready  = 1'b1;
    step();
    step();
    pe_ready = 1'b0;
    chk_pkts_zero("idle_out_start");

    // MODE1 full load then drain
    do_load(MODE1, 8'h00, 8'h00, 1'b0);
    do_drain(0);

    // MODE4 into bank1
    do_load(MODE4, 8'h30, 8'h11, 1'b0);
    do_drain(0);

    // MODE2 and MODE3, first drain with stalling PE
    do_load(MODE2, 8'h50, 8'h07, 1'b0);
    do_load(MODE3, 8'h70, 8'h03, 1'b0);
    do_drain(1);
    do_drain(0);

    // Concurrent drain of bank0 and random-valid fill of bank1
    do_load(MODE1, 8'h90, 8'h05, 1'b0);
    fork
      do_drain(2);
      do_load(MODE3, 8'hB0, 8'h0D, 1'b1);
    join
    do_load(MODE4, 8'hC4, 8'h21, 1'b0);
    chk("both_full", 64'(bank_full), 64'd3);
    mode_in    = MODE2;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("load_reject_pulse", 64'(load_reject), 64'd1);
    chk("mem_req_on_reject", 64'(mem_req), 64'd0);
    step();
    chk("load_reject_one_cycle", 64'(load_reject), 64'd0);
    chk("mem_req_stays_low", 64'(mem_req), 64'd0);
    do_drain(1);
    do_drain(0);

    // Reset in the middle of a fill and a drain
    do_load(MODE1, 8'h20, 8'h01, 1'b0);
    push_sets(m_drain);
    mode_in    = MODE2;
    load_start = 1'b1;
    out_start  = 1'b1;
    step();
    load_start = 1'b0;
    out_start  = 1'b0;
    mem_valid  = 1'b1;
    pe_ready   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      mem_data = {$urandom, $urandom};
      step();
    end
    rst_n = 1'b1;
    step();
    mem_valid = 1'b0;
    pe_ready  = 1'b0;
    chk("midrst_mem_req", 64'(mem_req), 64'd0);
    chk("midrst_bank_full", 64'(bank_full), 64'd0);
    chk("midrst_out_done", 64'(out_done), 64'd0);
    chk_pkts_zero("midrst_pkt");
    sb.delete();
    sets_seen = 0;
    exp_done  = 1'b0;
    m_fill    = 0;
    m_drain   = 0;
    rst_n     = 1'b0;
    step();

    // Buffer is usable again after the abort
    do_load(MODE4, 8'h44, 8'h09, 1'b0);
    do_drain(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
